// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int         BCD_DIGITS  = 3;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= ADD3_THRESH) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative shift-add-3 binary to three-digit BCD converter, one bit per clock
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int DIG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [DIG_W-1:0] dig_hund,
    output logic [DIG_W-1:0] dig_tens,
    output logic [DIG_W-1:0] dig_ones
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * BCD_DIGITS;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [BIN_W-1:0]   r_bin;
    logic [SCR_W-1:0]   r_scratch;
    logic [SCR_W-1:0]   w_adj;
    logic               r_done;
    logic [DIG_W-1:0]   r_hund;
    logic [DIG_W-1:0]   r_tens;
    logic [DIG_W-1:0]   r_ones;
    logic               w_last_shift;

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nibble (r_scratch[4*g +: 4]),
                .o_nibble (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign w_last_shift = (r_count == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last_shift) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Digits only change on the FINISH edge so partial scratch values never reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_done    <= 1'b0;
            r_hund    <= '0;
            r_tens    <= '0;
            r_ones    <= '0;
        end else begin
            r_done <= (r_state == FINISH);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= SCR_W'({w_adj, r_bin[BIN_W-1]});
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_count   <= r_count + CNT_W'(1);
                end
                FINISH: begin
                    r_hund <= DIG_W'(r_scratch[11:8]);
                    r_tens <= DIG_W'(r_scratch[7:4]);
                    r_ones <= DIG_W'(r_scratch[3:0]);
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign dig_hund = r_hund;
    assign dig_tens = r_tens;
    assign dig_ones = r_ones;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;
    localparam int DIG_W = 8;

    typedef struct {
        int h;
        int t;
        int o;
    } digits_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [DIG_W-1:0] dig_hund;
    logic [DIG_W-1:0] dig_tens;
    logic [DIG_W-1:0] dig_ones;

    digits_t sb[$];
    digits_t last;
    int      checks    = 0;
    int      failures  = 0;
    int      cycle     = 0;
    int      k_cycle   = 0;
    int      done_cyc  = 0;
    int      prev_done = 0;
    int      extra;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIG_W(DIG_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .dig_hund (dig_hund),
        .dig_tens (dig_tens),
        .dig_ones (dig_ones)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic digits_t model(input int v);
        digits_t d;
        d.h = v / 100;
        d.t = (v / 10) % 10;
        d.o = v % 10;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_digits(input string tag, input digits_t e);
        check({tag, "_hund"}, 32'(dig_hund), e.h);
        check({tag, "_tens"}, 32'(dig_tens), e.t);
        check({tag, "_ones"}, 32'(dig_ones), e.o);
    endtask

    // Drives start for one edge (edge k) and pushes the reference result.
    task automatic issue(input int v);
        start  = 1'b1;
        bin_in = BIN_W'(v);
        sb.push_back(model(v));
        tick();
        start   = 1'b0;
        k_cycle = cycle;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done(input string tag);
        bit      hold_ok = 1'b1;
        digits_t e;
        while (done !== 1'b1 && (cycle - k_cycle) < 20) begin
            if (32'(dig_hund) !== last.h || 32'(dig_tens) !== last.t || 32'(dig_ones) !== last.o)
                hold_ok = 1'b0;
            if (busy !== 1'b1) hold_ok = 1'b0;
            tick();
        end
        check({tag, "_hold_busy"}, 32'(hold_ok), 1);
        check({tag, "_latency"}, cycle - k_cycle, 9);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_in_done"}, 32'(busy), 0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_digits(tag, e);
            last = e;
        end
        prev_done = done_cyc;
        done_cyc  = cycle;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        last   = '{0, 0, 0};
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check_digits("rst", '{0, 0, 0});

        issue(254);
        wait_done("c254");

        issue(255);
        wait_done("c255");
        issue(0);
        wait_done("c0");
        check("period_0", done_cyc - prev_done, 10);
        issue(9);
        wait_done("c9");
        check("period_9", done_cyc - prev_done, 10);
        tick();
        check("done_one_cycle", 32'(done), 0);

        issue(100);
        repeat (3) tick();
        start  = 1'b1;
        bin_in = BIN_W'(77);
        tick();
        start = 1'b0;
        wait_done("busy_start");
        extra = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("no_extra_done", extra, 0);
        check("sb_empty", sb.size(), 0);

        issue(199);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_front());
        last = '{0, 0, 0};
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check_digits("abort", last);
        extra = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("abort_no_done", extra, 0);

        reset  = 1'b1;
        start  = 1'b1;
        bin_in = BIN_W'(50);
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_dom_busy", 32'(busy), 0);
        tick();
        check("rst_dom_busy2", 32'(busy), 0);
        check("rst_dom_done", 32'(done), 0);

        for (int v = 0; v < 256; v++) begin
            issue(v);
            wait_done("sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary operand width.
REQ-002 SHALL have parameter DIG_W, default 8, width of each digit output; it matches the time-multiplexer in1/in2/in3 width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, conversion request, sampled at a rising edge.
REQ-006 SHALL have port bin_in, input, BIN_W, unsigned value to convert, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when new digits are valid.
REQ-009 SHALL have port dig_hund, output, DIG_W, hundreds digit, zero-extended; drives in1.
REQ-010 SHALL have port dig_tens, output, DIG_W, tens digit, zero-extended; drives in2.
REQ-011 SHALL have port dig_ones, output, DIG_W, ones digit, zero-extended; drives in3.

Function
REQ-012 SHALL implement the iterative shift-add-3 (double dabble) method, one bit per clock.
REQ-013 SHALL use FSM states IDLE, SHIFT and FINISH.
REQ-014 IDLE with start=1 at edge k: SHALL capture bin_in, clear the BCD scratch register and count, and go to SHIFT.
REQ-015 SHIFT, each edge: SHALL add 3 to every scratch BCD nibble >=5, then shift left one bit with the next MSB of the captured operand; increment count.
REQ-016 SHALL perform exactly BIN_W shifts, at edges k+1..k+BIN_W, then enter FINISH.
REQ-017 FINISH at edge k+BIN_W+1: SHALL load all three digit outputs simultaneously, pulse done for exactly one cycle, and return to IDLE.
REQ-018 Latency: with BIN_W=8, done SHALL be high in the cycle after edge k+9.
REQ-019 busy SHALL equal (state != IDLE); it is low in the done cycle.
REQ-020 Digit outputs SHALL hold their last value between conversions and never expose partial results.
REQ-021 start while busy (SHIFT or FINISH) SHALL be ignored, with no queueing.
REQ-022 start in the done cycle (state IDLE) SHALL be accepted; the back-to-back period is 10 cycles.
REQ-023 bin_in changes after acceptance SHALL not affect the conversion in progress.
REQ-024 Each digit value SHALL be in the range 0..9; the hundreds digit is at most 2 for BIN_W=8; upper DIG_W-4 bits SHALL be 0.

Reset
REQ-025 reset=1 at an edge SHALL force state IDLE and set busy=0, done=0, all digit outputs=0, count=0 and scratch=0.
REQ-026 reset SHALL dominate start in the same cycle.
REQ-027 reset during SHIFT or FINISH SHALL abort the conversion; no done pulse is produced.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the state enum, BCD_DIGITS=3 and the ADD3_THRESH=5 constant.
REQ-029 Per-nibble correction SHALL be the sub-module bcd_add3 (combinational, 4-bit in and out), instantiated 3 times.
REQ-030 The top level SHALL contain the FSM, count, operand shift register, scratch register and output registers only.

Verification
REQ-031 Reset held 5 cycles, then released -> busy=0, done=0, digits 0,0,0.
REQ-032 start with bin_in=254 -> done high in the cycle after edge k+9, with dig_hund=2, dig_tens=5, dig_ones=4.
REQ-033 start with 255, then 0, then 9, each issued in the previous done cycle -> 2,5,5, then 0,0,0, then 0,0,9, with done every 10 cycles.
REQ-034 start with 100, then start=1 with bin_in=77 at edge k+4 -> result 1,0,0 only; no second done pulse.
REQ-035 start with 199, reset asserted at edge k+5 -> no done pulse, digits 0,0,0, busy=0 next cycle.
REQ-036 Exhaustive sweep of 0..255 against a reference model -> all digits match and busy/done timing matches every conversion.
